// File: rtl/agrupate_ctrl.sv
// Job sequencer wrapping one AGRUPATE instance: configures it, gates exactly N*R input beats,
// counts N*ceil(R/GROUP_SIZE) grouped output beats, then pulses done. Optional: AGRUPATE_CTRL_PERF_EN.
module agrupate_ctrl #(
    parameter int GROUP_SIZE             = 4,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              job_valid,
    output logic                              job_ready,
    input  logic [LOG_MAX_ITERS-1:0]          job_num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] job_num_reads_per_iter,
    output logic                              cfg_configure,
    output logic [LOG_MAX_ITERS-1:0]          cfg_num_iters,
    output logic [LOG_MAX_READS_PER_ITER-1:0] cfg_num_reads_per_iter,
    input  logic                              src_valid,
    output logic                              src_avail,
    output logic                              agr_valid_in,
    input  logic                              agr_avail_out,
    input  logic                              agr_valid_out,
    input  logic                              sink_avail,
    output logic                              agr_avail_in,
    output logic                              busy,
    output logic                              done
`ifdef AGRUPATE_CTRL_PERF_EN
    ,
    output logic [31:0]                       busy_cycles
`endif
);

    localparam int IW       = LOG_MAX_ITERS;
    localparam int RW       = LOG_MAX_READS_PER_ITER;
    localparam int GW       = LOG_MAX_READS_PER_ITER + 1;
    localparam int GS_SHIFT = $clog2(GROUP_SIZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CONFIG = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [IW-1:0] cfg_iters_reg;
    logic [RW-1:0] cfg_reads_reg;
    logic [GW-1:0] groups_reg;
    logic [RW-1:0] rd_cnt_reg;
    logic [IW-1:0] in_iter_reg;
    logic [GW-1:0] grp_cnt_reg;
    logic [IW-1:0] out_iter_reg;
    logic          out_done_reg;

    logic in_gate;
    logic out_gate;
    logic job_accept;
    logic job_zero;
    logic in_fire;
    logic out_fire;
    logic last_read;
    logic last_in_iter;
    logic last_grp;
    logic last_out_iter;
    logic last_in;
    logic last_out;
    logic out_complete;

    assign in_gate  = (state_reg == S_RUN);
    assign out_gate = (state_reg == S_RUN) || (state_reg == S_DRAIN);

    assign job_ready     = (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign done          = (state_reg == S_DONE);
    assign cfg_configure = (state_reg == S_CONFIG);
    assign cfg_num_iters          = cfg_iters_reg;
    assign cfg_num_reads_per_iter = cfg_reads_reg;

    // Handshakes depend only on registered state and the opposite-side handshake
    assign agr_valid_in = in_gate & src_valid;
    assign src_avail    = in_gate & agr_avail_out;
    assign agr_avail_in = out_gate & sink_avail;

    assign job_accept = job_ready & job_valid;
    assign job_zero   = (job_num_iters == '0) || (job_num_reads_per_iter == '0);
    assign in_fire    = in_gate & src_valid & agr_avail_out;
    assign out_fire   = out_gate & agr_valid_out & sink_avail;

    assign last_read     = (rd_cnt_reg == cfg_reads_reg - RW'(1));
    assign last_in_iter  = (in_iter_reg == cfg_iters_reg - IW'(1));
    assign last_grp      = (grp_cnt_reg == groups_reg - GW'(1));
    assign last_out_iter = (out_iter_reg == cfg_iters_reg - IW'(1));
    assign last_in       = in_fire & last_read & last_in_iter;
    assign last_out      = out_fire & ~out_done_reg & last_grp & last_out_iter;
    // An early finish of the output side (before the input side) must not be forgotten
    assign out_complete  = last_out | out_done_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (job_valid) state_next = job_zero ? S_DONE : S_CONFIG;
            S_CONFIG: state_next = S_RUN;
            S_RUN:    if (last_in) state_next = out_complete ? S_DONE : S_DRAIN;
            S_DRAIN:  if (out_complete) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_iters_reg <= '0;
            cfg_reads_reg <= '0;
            groups_reg    <= '0;
            rd_cnt_reg    <= '0;
            in_iter_reg   <= '0;
            grp_cnt_reg   <= '0;
            out_iter_reg  <= '0;
            out_done_reg  <= 1'b0;
        end else if (job_accept) begin
            cfg_iters_reg <= job_num_iters;
            cfg_reads_reg <= job_num_reads_per_iter;
            rd_cnt_reg    <= '0;
            in_iter_reg   <= '0;
            grp_cnt_reg   <= '0;
            out_iter_reg  <= '0;
            out_done_reg  <= 1'b0;
        end else begin
            // Outputs per iteration: ceil(R / GROUP_SIZE), one bit wider than R
            if (state_reg == S_CONFIG) begin
                groups_reg <= ({1'b0, cfg_reads_reg} + GW'(GROUP_SIZE - 1)) >> GS_SHIFT;
            end
            if (in_fire) begin
                if (last_read) begin
                    rd_cnt_reg  <= '0;
                    in_iter_reg <= in_iter_reg + IW'(1);
                end else begin
                    rd_cnt_reg <= rd_cnt_reg + RW'(1);
                end
            end
            if (out_fire && !out_done_reg) begin
                if (last_grp) begin
                    grp_cnt_reg <= '0;
                    if (last_out_iter) begin
                        out_done_reg <= 1'b1;
                    end else begin
                        out_iter_reg <= out_iter_reg + IW'(1);
                    end
                end else begin
                    grp_cnt_reg <= grp_cnt_reg + GW'(1);
                end
            end
        end
    end

`ifdef AGRUPATE_CTRL_PERF_EN
    logic [31:0] busy_cycles_reg;

    // Clears on accept, counts busy cycles, saturates, and holds across IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cycles_reg <= '0;
        end else if (job_accept) begin
            busy_cycles_reg <= '0;
        end else if (busy && (busy_cycles_reg != 32'hFFFF_FFFF)) begin
            busy_cycles_reg <= busy_cycles_reg + 32'd1;
        end
    end

    assign busy_cycles = busy_cycles_reg;
`endif

endmodule
